// File: rtl/wm8731_cfg_seq.sv
// WM8731 codec configuration sequencer: walks a fixed 12-entry register table,
// issuing one I2C write per entry with retry, timeout and inter-write spacing.
module wm8731_cfg_seq #(
   parameter int unsigned INTER_DELAY = 50,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned TIMEOUT     = 4096
) (
   input  logic        sys_clk50MHz,
   input  logic        sys_rst_n,
   input  logic        start,
   output logic        i2c_req,
   output logic [7:0]  i2c_dev_addr,
   output logic [15:0] i2c_word,
   input  logic        i2c_ack,
   input  logic        i2c_nack,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  idx
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int DLY_W  = (INTER_DELAY > 1) ? $clog2(INTER_DELAY + 1) : 1;
   localparam int RTY_W  = $clog2(MAX_RETRY + 2);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((INTER_DELAY > 0) ? INTER_DELAY - 1 : 0);
   localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
   localparam logic [3:0]        LAST_IDX  = 4'd11;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DELAY, DONE, ERROR} state_t;

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [DLY_W-1:0]  delay_cnt_q, delay_cnt_d;
   logic [15:0]       word_q, word_d;
   logic              ok_q, ok_d;
   logic              fail;

   function automatic logic [15:0] table_word(input logic [3:0] i);
      case (i)
         4'd0:    table_word = 16'h1E00;
         4'd1:    table_word = 16'h0C10;
         4'd2:    table_word = 16'h0017;
         4'd3:    table_word = 16'h0217;
         4'd4:    table_word = 16'h0479;
         4'd5:    table_word = 16'h0679;
         4'd6:    table_word = 16'h0812;
         4'd7:    table_word = 16'h0A00;
         4'd8:    table_word = 16'h0E42;
         4'd9:    table_word = 16'h1000;
         4'd10:   table_word = 16'h1201;
         4'd11:   table_word = 16'h0C00;
         default: table_word = 16'h0000;
      endcase
   endfunction

   always_ff @(posedge sys_clk50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         retry_q     <= '0;
         wait_cnt_q  <= '0;
         delay_cnt_q <= '0;
         word_q      <= '0;
         ok_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         wait_cnt_q  <= wait_cnt_d;
         delay_cnt_q <= delay_cnt_d;
         word_q      <= word_d;
         ok_q        <= ok_d;
      end
   end

   // ok_q remembers whether the delay being served follows an ack (advance)
   // or a failure (reissue the same entry).
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      retry_d     = retry_q;
      wait_cnt_d  = wait_cnt_q;
      delay_cnt_d = delay_cnt_q;
      word_d      = word_q;
      ok_d        = ok_q;
      fail        = 1'b0;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d     = REQ;
               idx_d       = '0;
               retry_d     = '0;
               wait_cnt_d  = '0;
               delay_cnt_d = '0;
               ok_d        = 1'b0;
               word_d      = table_word(4'd0);
            end
         end
         REQ: begin
            state_d    = WAIT;
            wait_cnt_d = '0;
         end
         WAIT: begin
            if (i2c_nack) begin
               fail = 1'b1;
            end else if (i2c_ack) begin
               state_d     = DELAY;
               delay_cnt_d = '0;
               ok_d        = 1'b1;
            end else if (wait_cnt_q >= WAIT_LAST) begin
               fail = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (fail) begin
               if (retry_q >= RTY_MAX) begin
                  state_d = ERROR;
               end else begin
                  state_d     = DELAY;
                  retry_d     = retry_q + 1'b1;
                  delay_cnt_d = '0;
                  ok_d        = 1'b0;
               end
            end
         end
         DELAY: begin
            if (delay_cnt_q >= DLY_LAST) begin
               if (!ok_q) begin
                  state_d = REQ;
                  word_d  = table_word(idx_q);
               end else if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  state_d = REQ;
                  idx_d   = idx_q + 4'd1;
                  retry_d = '0;
                  word_d  = table_word(idx_q + 4'd1);
               end
            end else begin
               delay_cnt_d = delay_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign i2c_req      = (state_q == REQ) || (state_q == WAIT);
   assign busy         = (state_q == REQ) || (state_q == WAIT) || (state_q == DELAY);
   assign done         = (state_q == DONE);
   assign err          = (state_q == ERROR);
   assign idx          = idx_q;
   assign i2c_word     = word_q;
   assign i2c_dev_addr = 8'h34;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Self-checking bench for wm8731_cfg_seq: a scripted I2C responder drives
// per-attempt responses and a plan-level model predicts the write sequence.
module tb_wm8731_cfg_seq;

   localparam int unsigned INTER_DELAY = 50;
   localparam int unsigned MAX_RETRY   = 3;
   localparam int unsigned TIMEOUT     = 4096;

   localparam int K_ACK  = 0;
   localparam int K_NACK = 1;
   localparam int K_BOTH = 2;
   localparam int K_NONE = 3;

   logic        sys_clk50MHz = 1'b0;
   logic        sys_rst_n    = 1'b0;
   logic        start        = 1'b0;
   logic        i2c_ack      = 1'b0;
   logic        i2c_nack     = 1'b0;
   logic        i2c_req;
   logic [7:0]  i2c_dev_addr;
   logic [15:0] i2c_word;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  idx;

   int checks = 0;
   int errors = 0;

   logic [15:0] tbl [12] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                             16'h0812, 16'h0A00, 16'h0E42, 16'h1000, 16'h1201, 16'h0C00};

   int          plan_q[$];
   logic [15:0] obs_word_q[$];
   int          obs_idx_q[$];
   int          obs_gap_q[$];
   int          obs_high_q[$];
   logic [15:0] exp_word_q[$];
   int          exp_idx_q[$];
   bit          exp_done;
   bit          exp_err;
   int          exp_final_idx;
   int          exp_used;
   bit          stray_start = 1'b0;
   bit          stray_ack   = 1'b0;

   wm8731_cfg_seq #(
      .INTER_DELAY(INTER_DELAY),
      .MAX_RETRY  (MAX_RETRY),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .sys_clk50MHz(sys_clk50MHz),
      .sys_rst_n   (sys_rst_n),
      .start       (start),
      .i2c_req     (i2c_req),
      .i2c_dev_addr(i2c_dev_addr),
      .i2c_word    (i2c_word),
      .i2c_ack     (i2c_ack),
      .i2c_nack    (i2c_nack),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .idx         (idx)
   );

   always #10 sys_clk50MHz = ~sys_clk50MHz;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Model: walk the table from entry 0 consuming one planned response per
   // attempt; an ack moves on, anything else costs one retry of the budget.
   function automatic void build_model();
      int i;
      int retry;
      int k;
      exp_word_q.delete();
      exp_idx_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      i = 0;
      retry = 0;
      k = 0;
      while (k < plan_q.size() && !exp_done && !exp_err) begin
         exp_word_q.push_back(tbl[i]);
         exp_idx_q.push_back(i);
         if (plan_q[k] == K_ACK) begin
            if (i == 11) exp_done = 1'b1;
            else begin
               i++;
               retry = 0;
            end
         end else begin
            retry++;
            if (retry > int'(MAX_RETRY)) exp_err = 1'b1;
         end
         k++;
      end
      exp_used = k;
      exp_final_idx = i;
      while (plan_q.size() > exp_used) void'(plan_q.pop_back());
   endfunction

   task automatic do_reset();
      @(negedge sys_clk50MHz);
      sys_rst_n = 1'b0;
      start     = 1'b0;
      i2c_ack   = 1'b0;
      i2c_nack  = 1'b0;
      repeat (3) @(negedge sys_clk50MHz);
      sys_rst_n = 1'b1;
      @(negedge sys_clk50MHz);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge sys_clk50MHz);
      start = 1'b0;
   endtask

   // Serves one planned response per request; records what the DUT put out.
   task automatic drive_plan();
      int gap;
      int high;
      int lat;
      int pre_gap;
      obs_word_q.delete();
      obs_idx_q.delete();
      obs_gap_q.delete();
      obs_high_q.delete();
      pre_gap = 0;
      foreach (plan_q[k]) begin
         gap = pre_gap;
         pre_gap = 0;
         while (!i2c_req && gap < int'(INTER_DELAY) + 20) begin
            gap++;
            @(negedge sys_clk50MHz);
         end
         if (!i2c_req) return;
         obs_word_q.push_back(i2c_word);
         obs_idx_q.push_back(int'(idx));
         obs_gap_q.push_back(gap);
         high = 0;
         if (plan_q[k] == K_NONE) begin
            while (i2c_req && high < int'(TIMEOUT) + 20) begin
               high++;
               @(negedge sys_clk50MHz);
            end
         end else begin
            lat = $urandom_range(3, 40);
            for (int c = 0; c < lat; c++) begin
               start = stray_start && (c == 1);
               high++;
               @(negedge sys_clk50MHz);
            end
            start    = 1'b0;
            i2c_ack  = (plan_q[k] != K_NACK);
            i2c_nack = (plan_q[k] != K_ACK);
            @(negedge sys_clk50MHz);
            i2c_ack  = 1'b0;
            i2c_nack = 1'b0;
            if (stray_ack) begin
               repeat (4) @(negedge sys_clk50MHz);
               i2c_ack = 1'b1;
               @(negedge sys_clk50MHz);
               i2c_ack = 1'b0;
               pre_gap = 5;
            end
         end
         obs_high_q.push_back(high);
      end
   endtask

   task automatic wait_finish();
      int cycles;
      cycles = 0;
      while (!(done || err) && cycles < int'(INTER_DELAY) + 20) begin
         cycles++;
         @(negedge sys_clk50MHz);
      end
   endtask

   task automatic test_reset();
      int active;
      @(negedge sys_clk50MHz);
      checks++;
      if ({i2c_req, i2c_word, busy, done, err, idx} !== 24'h0 || i2c_dev_addr !== 8'h34) begin
         errors++;
         $display("[TB] FAIL reset_values: got req=%b word=%h busy=%b done=%b err=%b idx=%0d addr=%h required all 0, addr 34",
                  i2c_req, i2c_word, busy, done, err, idx, i2c_dev_addr);
      end
      sys_rst_n = 1'b1;
      active = 0;
      for (int c = 0; c < 20; c++) begin
         i2c_ack  = (c == 5);
         i2c_nack = (c == 9);
         @(negedge sys_clk50MHz);
         if (busy || i2c_req || done || err) active++;
      end
      i2c_ack  = 1'b0;
      i2c_nack = 1'b0;
      checks++;
      if (active != 0) begin
         errors++;
         $display("[TB] FAIL idle_hold: got %0d active cycles required 0", active);
      end
   endtask

   task automatic test_nominal();
      do_reset();
      plan_q.delete();
      repeat (12) plan_q.push_back(K_ACK);
      build_model();
      pulse_start();
      drive_plan();
      wait_finish();
      checks++;
      if (obs_word_q.size() != exp_word_q.size()) begin
         errors++;
         $display("[TB] FAIL nominal_count: got %0d required %0d", obs_word_q.size(), exp_word_q.size());
      end
      for (int i = 0; i < exp_word_q.size() && i < obs_word_q.size(); i++) begin
         checks++;
         if (obs_word_q[i] !== exp_word_q[i] || obs_idx_q[i] != exp_idx_q[i]) begin
            errors++;
            $display("[TB] FAIL nominal_word[%0d]: got %h/idx %0d required %h/idx %0d",
                     i, obs_word_q[i], obs_idx_q[i], exp_word_q[i], exp_idx_q[i]);
         end
         if (i > 0) begin
            checks++;
            if (obs_gap_q[i] != int'(INTER_DELAY)) begin
               errors++;
               $display("[TB] FAIL nominal_gap[%0d]: got %0d required %0d", i, obs_gap_q[i], INTER_DELAY);
            end
         end
      end
      checks++;
      if ({done, err, busy, i2c_req, idx} !== {exp_done, exp_err, 2'b00, 4'(exp_final_idx)}) begin
         errors++;
         $display("[TB] FAIL nominal_final: got done=%b err=%b busy=%b req=%b idx=%0d required done=%b err=%b busy=0 req=0 idx=%0d",
                  done, err, busy, i2c_req, idx, exp_done, exp_err, exp_final_idx);
      end
   endtask

   task automatic test_restart();
      pulse_start();
      checks++;
      if ({done, err, busy, i2c_req, idx} !== 8'b00110000 || i2c_word !== 16'h1E00) begin
         errors++;
         $display("[TB] FAIL restart_clear: got done=%b err=%b busy=%b req=%b idx=%0d word=%h required 0 0 1 1 0 1e00",
                  done, err, busy, i2c_req, idx, i2c_word);
      end
      plan_q.delete();
      repeat (12) plan_q.push_back(K_ACK);
      build_model();
      drive_plan();
      wait_finish();
      checks++;
      if (obs_word_q.size() != exp_word_q.size()) begin
         errors++;
         $display("[TB] FAIL restart_count: got %0d required %0d", obs_word_q.size(), exp_word_q.size());
      end
      for (int i = 0; i < exp_word_q.size() && i < obs_word_q.size(); i++) begin
         checks++;
         if (obs_word_q[i] !== exp_word_q[i] || obs_idx_q[i] != exp_idx_q[i]) begin
            errors++;
            $display("[TB] FAIL restart_word[%0d]: got %h/idx %0d required %h/idx %0d",
                     i, obs_word_q[i], obs_idx_q[i], exp_word_q[i], exp_idx_q[i]);
         end
      end
      checks++;
      if ({done, err, busy, i2c_req, idx} !== {exp_done, exp_err, 2'b00, 4'(exp_final_idx)}) begin
         errors++;
         $display("[TB] FAIL restart_final: got done=%b err=%b busy=%b idx=%0d required done=%b err=%b idx=%0d",
                  done, err, busy, idx, exp_done, exp_err, exp_final_idx);
      end
   endtask

   task automatic test_single_nack();
      do_reset();
      plan_q.delete();
      repeat (4) plan_q.push_back(K_ACK);
      plan_q.push_back(K_NACK);
      repeat (8) plan_q.push_back(K_ACK);
      build_model();
      pulse_start();
      drive_plan();
      wait_finish();
      checks++;
      if (obs_word_q.size() != exp_word_q.size()) begin
         errors++;
         $display("[TB] FAIL nack1_count: got %0d required %0d", obs_word_q.size(), exp_word_q.size());
      end
      for (int i = 0; i < exp_word_q.size() && i < obs_word_q.size(); i++) begin
         checks++;
         if (obs_word_q[i] !== exp_word_q[i] || obs_idx_q[i] != exp_idx_q[i]) begin
            errors++;
            $display("[TB] FAIL nack1_word[%0d]: got %h/idx %0d required %h/idx %0d",
                     i, obs_word_q[i], obs_idx_q[i], exp_word_q[i], exp_idx_q[i]);
         end
         if (i > 0) begin
            checks++;
            if (obs_gap_q[i] != int'(INTER_DELAY)) begin
               errors++;
               $display("[TB] FAIL nack1_gap[%0d]: got %0d required %0d", i, obs_gap_q[i], INTER_DELAY);
            end
         end
      end
      checks++;
      if ({done, err, busy, i2c_req, idx} !== {exp_done, exp_err, 2'b00, 4'(exp_final_idx)}) begin
         errors++;
         $display("[TB] FAIL nack1_final: got done=%b err=%b busy=%b idx=%0d required done=%b err=%b idx=%0d",
                  done, err, busy, idx, exp_done, exp_err, exp_final_idx);
      end
   endtask

   task automatic test_persistent_nack();
      do_reset();
      plan_q.delete();
      repeat (2) plan_q.push_back(K_ACK);
      repeat (MAX_RETRY + 1) plan_q.push_back(K_NACK);
      build_model();
      pulse_start();
      drive_plan();
      wait_finish();
      checks++;
      if (obs_word_q.size() != exp_word_q.size()) begin
         errors++;
         $display("[TB] FAIL nackp_count: got %0d required %0d", obs_word_q.size(), exp_word_q.size());
      end
      for (int i = 0; i < exp_word_q.size() && i < obs_word_q.size(); i++) begin
         checks++;
         if (obs_word_q[i] !== exp_word_q[i] || obs_idx_q[i] != exp_idx_q[i]) begin
            errors++;
            $display("[TB] FAIL nackp_word[%0d]: got %h/idx %0d required %h/idx %0d",
                     i, obs_word_q[i], obs_idx_q[i], exp_word_q[i], exp_idx_q[i]);
         end
      end
      checks++;
      if ({done, err, busy, i2c_req, idx} !== {exp_done, exp_err, 2'b00, 4'(exp_final_idx)}) begin
         errors++;
         $display("[TB] FAIL nackp_final: got done=%b err=%b busy=%b req=%b idx=%0d required done=%b err=%b idx=%0d",
                  done, err, busy, i2c_req, idx, exp_done, exp_err, exp_final_idx);
      end
      pulse_start();
      checks++;
      if ({done, err, i2c_req, idx} !== 7'b0010000 || i2c_word !== 16'h1E00) begin
         errors++;
         $display("[TB] FAIL err_restart: got done=%b err=%b req=%b idx=%0d word=%h required 0 0 1 0 1e00",
                  done, err, i2c_req, idx, i2c_word);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      plan_q.delete();
      repeat (MAX_RETRY + 1) plan_q.push_back(K_NONE);
      build_model();
      pulse_start();
      drive_plan();
      wait_finish();
      checks++;
      if (obs_word_q.size() != exp_word_q.size()) begin
         errors++;
         $display("[TB] FAIL timeout_count: got %0d required %0d", obs_word_q.size(), exp_word_q.size());
      end
      for (int i = 0; i < exp_word_q.size() && i < obs_word_q.size(); i++) begin
         checks++;
         if (obs_word_q[i] !== exp_word_q[i] || obs_high_q[i] < int'(TIMEOUT) || obs_high_q[i] > int'(TIMEOUT) + 1) begin
            errors++;
            $display("[TB] FAIL timeout_attempt[%0d]: got word %h high %0d required word %h high %0d..%0d",
                     i, obs_word_q[i], obs_high_q[i], exp_word_q[i], TIMEOUT, TIMEOUT + 1);
         end
      end
      checks++;
      if ({done, err, busy, i2c_req, idx} !== {exp_done, exp_err, 2'b00, 4'(exp_final_idx)}) begin
         errors++;
         $display("[TB] FAIL timeout_final: got done=%b err=%b busy=%b req=%b idx=%0d required done=%b err=%b idx=%0d",
                  done, err, busy, i2c_req, idx, exp_done, exp_err, exp_final_idx);
      end
   endtask

   task automatic test_corner();
      do_reset();
      stray_start = 1'b1;
      stray_ack   = 1'b1;
      plan_q.delete();
      repeat (7) plan_q.push_back(K_ACK);
      plan_q.push_back(K_BOTH);
      repeat (5) plan_q.push_back(K_ACK);
      build_model();
      pulse_start();
      drive_plan();
      stray_start = 1'b0;
      stray_ack   = 1'b0;
      wait_finish();
      checks++;
      if (obs_word_q.size() != exp_word_q.size()) begin
         errors++;
         $display("[TB] FAIL corner_count: got %0d required %0d", obs_word_q.size(), exp_word_q.size());
      end
      for (int i = 0; i < exp_word_q.size() && i < obs_word_q.size(); i++) begin
         checks++;
         if (obs_word_q[i] !== exp_word_q[i] || obs_idx_q[i] != exp_idx_q[i]) begin
            errors++;
            $display("[TB] FAIL corner_word[%0d]: got %h/idx %0d required %h/idx %0d",
                     i, obs_word_q[i], obs_idx_q[i], exp_word_q[i], exp_idx_q[i]);
         end
      end
      checks++;
      if ({done, err, busy, i2c_req, idx} !== {exp_done, exp_err, 2'b00, 4'(exp_final_idx)}) begin
         errors++;
         $display("[TB] FAIL corner_final: got done=%b err=%b busy=%b idx=%0d required done=%b err=%b idx=%0d",
                  done, err, busy, idx, exp_done, exp_err, exp_final_idx);
      end
   endtask

   task automatic test_random();
      int r;
      for (int run = 0; run < 3; run++) begin
         do_reset();
         plan_q.delete();
         for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 99);
            plan_q.push_back((r < 70) ? K_ACK : (r < 88) ? K_NACK : K_BOTH);
         end
         build_model();
         pulse_start();
         drive_plan();
         wait_finish();
         checks++;
         if (obs_word_q.size() != exp_word_q.size()) begin
            errors++;
            $display("[TB] FAIL random%0d_count: got %0d required %0d", run, obs_word_q.size(), exp_word_q.size());
         end
         for (int i = 0; i < exp_word_q.size() && i < obs_word_q.size(); i++) begin
            checks++;
            if (obs_word_q[i] !== exp_word_q[i] || obs_idx_q[i] != exp_idx_q[i] ||
                (i > 0 && obs_gap_q[i] != int'(INTER_DELAY))) begin
               errors++;
               $display("[TB] FAIL random%0d_word[%0d]: got %h/idx %0d/gap %0d required %h/idx %0d/gap %0d",
                        run, i, obs_word_q[i], obs_idx_q[i], obs_gap_q[i], exp_word_q[i], exp_idx_q[i], INTER_DELAY);
            end
         end
         checks++;
         if ({done, err, busy, i2c_req, idx} !== {exp_done, exp_err, 2'b00, 4'(exp_final_idx)}) begin
            errors++;
            $display("[TB] FAIL random%0d_final: got done=%b err=%b busy=%b idx=%0d required done=%b err=%b idx=%0d",
                     run, done, err, busy, idx, exp_done, exp_err, exp_final_idx);
         end
      end
   endtask

   task automatic test_reset_mid();
      int gap;
      int active;
      do_reset();
      plan_q.delete();
      repeat (6) plan_q.push_back(K_ACK);
      pulse_start();
      drive_plan();
      gap = 0;
      while (!i2c_req && gap < int'(INTER_DELAY) + 20) begin
         gap++;
         @(negedge sys_clk50MHz);
      end
      checks++;
      if (i2c_req !== 1'b1 || i2c_word !== 16'h0812 || idx !== 4'd6) begin
         errors++;
         $display("[TB] FAIL midreset_setup: got req=%b word=%h idx=%0d required 1 0812 6", i2c_req, i2c_word, idx);
      end
      repeat (5) @(negedge sys_clk50MHz);
      #3 sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({i2c_req, i2c_word, busy, done, err, idx} !== 24'h0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got req=%b word=%h busy=%b done=%b err=%b idx=%0d required all 0",
                  i2c_req, i2c_word, busy, done, err, idx);
      end
      @(negedge sys_clk50MHz);
      sys_rst_n = 1'b1;
      active = 0;
      repeat (10) begin
         @(negedge sys_clk50MHz);
         if (busy || i2c_req) active++;
      end
      checks++;
      if (active != 0) begin
         errors++;
         $display("[TB] FAIL midreset_idle: got %0d active cycles required 0", active);
      end
      pulse_start();
      checks++;
      if (i2c_req !== 1'b1 || i2c_word !== 16'h1E00 || idx !== 4'd0) begin
         errors++;
         $display("[TB] FAIL midreset_restart: got req=%b word=%h idx=%0d required 1 1e00 0", i2c_req, i2c_word, idx);
      end
   endtask

   initial begin
      $display("[TB] starting wm8731_cfg_seq bench");
      test_reset();
      test_nominal();
      test_restart();
      test_single_nack();
      test_persistent_nack();
      test_timeout();
      test_corner();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wm8731_cfg_seq.md
WM8731_CFG_SEQ -- requirements
Module: wm8731_cfg_seq

Interface
REQ-001 The block SHALL have parameter INTER_DELAY, default 50, giving idle clock cycles between two writes.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, giving the number of extra attempts per register after a failure.
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, giving the clock cycles to wait for ack/nack before declaring a failure.
REQ-004 The block SHALL have port sys_clk50MHz, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: pulse that begins the configuration sequence.
REQ-007 The block SHALL have port i2c_req, output, 1 bit: write request to the I2C master.
REQ-008 The block SHALL have port i2c_dev_addr, output, 8 bits: device write address, constant 0x34.
REQ-009 The block SHALL have port i2c_word, output, 16 bits: {reg_addr[6:0], reg_data[8:0]}.
REQ-010 The block SHALL have port i2c_ack, input, 1 bit: one-cycle pulse, write completed and acknowledged.
REQ-011 The block SHALL have port i2c_nack, input, 1 bit: one-cycle pulse, write failed.
REQ-012 The block SHALL have port busy, output, 1 bit: sequence in progress.
REQ-013 The block SHALL have port done, output, 1 bit: all registers written.
REQ-014 The block SHALL have port err, output, 1 bit: sequence aborted.
REQ-015 The block SHALL have port idx, output, 4 bits: current table index.

Function
REQ-016 The table SHALL hold 12 entries, indices 0..11, with i2c_word = 0x1E00, 0x0C10, 0x0017, 0x0217, 0x0479, 0x0679, 0x0812, 0x0A00, 0x0E42, 0x1000, 0x1201, 0x0C00.
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, DELAY, DONE and ERROR.
REQ-018 From IDLE, DONE or ERROR, start=1 SHALL clear done, err, idx and the retry count, and enter REQ with i2c_req=1 on the next edge.
REQ-019 start SHALL be ignored in REQ, WAIT and DELAY.
REQ-020 In REQ/WAIT, i2c_req SHALL stay 1, and i2c_word SHALL stay stable, until ack or nack is sampled.
REQ-021 On ack, i2c_req SHALL drop on the same edge and the FSM SHALL enter DELAY for exactly INTER_DELAY cycles.
REQ-022 After DELAY, if idx<11 then idx SHALL increment, the retry count SHALL clear, and the FSM SHALL enter REQ.
REQ-023 After DELAY, if idx=11 the FSM SHALL enter DONE.
REQ-024 On nack, or when the wait counter reaches TIMEOUT with neither pulse seen, i2c_req SHALL drop, the retry count SHALL increment, and the FSM SHALL enter DELAY with the same idx.
REQ-025 If the retry count would exceed MAX_RETRY, the FSM SHALL enter ERROR instead of DELAY.
REQ-026 ack and nack asserted in the same cycle SHALL be treated as nack.
REQ-027 ack or nack arriving outside WAIT SHALL be ignored.
REQ-028 busy SHALL be 1 exactly in REQ, WAIT and DELAY.
REQ-029 done SHALL be 1 only in DONE; err SHALL be 1 only in ERROR; both SHALL hold until the next start.
REQ-030 In ERROR, idx SHALL hold the index of the failing entry.
REQ-031 The wait and delay counters SHALL be sized from TIMEOUT and INTER_DELAY, and SHALL saturate rather than wrap.
REQ-032 i2c_word SHALL be a registered output.

Reset
REQ-033 sys_rst_n=0 SHALL immediately force IDLE, i2c_req=0, i2c_word=0x0000, busy=0, done=0, err=0, idx=0, and all counters to 0.
REQ-034 A reset asserted mid-transfer SHALL drop i2c_req at once, with no attempt to complete the write.
REQ-035 After reset release the block SHALL stay in IDLE until start.

Verification
REQ-036 Nominal run: start pulse; ack each req after 20 cycles -> 12 reqs with words in table order, gaps ≥50 cycles, done=1, busy=0, idx=11.
REQ-037 Single nack: nack on idx 4 once -> idx 4 (0x0479) reissued after 50 cycles, then sequence completes with done=1.
REQ-038 Persistent nack: nack every attempt at idx 2 -> 4 attempts, then err=1, idx=2, i2c_req=0, busy=0.
REQ-039 Timeout: no response at idx 0 -> req drops after 4096 cycles; after 3 retries err=1.
REQ-040 Corner events: ack+nack in the same cycle at idx 7 -> retry counted; start during busy -> no effect; second start after done -> sequence restarts at idx 0.
REQ-041 Reset in WAIT at idx 6 -> outputs at reset values immediately; start after release -> begins at 0x1E00.
